act_pingpong_buf: RTL
=====================

// Module: act_pingpong_buf
// PURPOSE
//  Double-banked activation buffer immediately downstream of the layer controller.
//  - Captures neuron results from the PE array for the layer in progress.
//  - On the controller's end-of-layer pulse, swaps banks and replays the stored
//    results as the input stream for the next layer.
//  - During the input layer, passes the external sample stream through instead.
// PARAMETERS
//  DEP  8   max neurons per layer (entries per bank)
//  DW   16  activation width, signed two's complement
//  CW   $clog2(DEP+1)  count width (localparam, derived)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_in       in   1   synchronous reset, active-high
//  layer_done   in   1   end-of-layer pulse from the controller; 1-cycle wide
//  input_layer  in   1   high: read side sources the external stream
//  feed_hold    in   1   high: stall the read pointer this cycle
//  ext_valid    in   1   external sample valid
//  ext_data     in   DW  external sample
//  wr_valid     in   1   PE result valid
//  wr_data      in   DW  PE result
//  rd_valid     out  1   rd_data carries a new activation
//  rd_data      out  DW  activation fed to the PE array
//  wr_count     out  CW  entries written to the current write bank
//  bank_sel     out  1   index of the current read bank; write bank = ~bank_sel
//  overflow     out  1   sticky: a write was dropped because the bank was full
// BEHAVIOUR
//  Reset:
//  - When rst_in=1 at a clk edge, all outputs and pointers go to 0: bank_sel, wr_ptr,
//    rd_ptr, rd_len, rd_valid, rd_data, wr_count, overflow.
//  - RAM contents are not reset.
//  - rst_in dominates every other input, including layer_done.
//  Write:
//  - If wr_valid=1 and wr_ptr<DEP: mem[~bank_sel][wr_ptr] <= wr_data and wr_ptr increments.
//  - wr_count equals wr_ptr.
//  - If wr_valid=1 and wr_ptr==DEP: the data is dropped, overflow<=1, and wr_ptr holds.
//  - Writes are accepted during input_layer.
//  Read, input_layer=1:
//  - rd_data<=ext_data and rd_valid<=ext_valid; 1-cycle latency.
//  - feed_hold is ignored.
//  - The banks are not read.
//  Read, input_layer=0:
//  - If feed_hold=0 and rd_ptr<rd_len: rd_data<=mem[bank_sel][rd_ptr], rd_valid<=1,
//    and rd_ptr increments. Latency is 1 cycle.
//  - Otherwise rd_valid<=0, rd_data holds its last value, and rd_ptr holds.
//  - Once rd_ptr==rd_len, rd_valid stays 0 until the next swap. No wrap-around.
//  Swap (layer_done=1, rst_in=0):
//  - Next cycle: bank_sel<=~bank_sel, rd_ptr<=0, wr_ptr<=0, wr_count<=0, rd_len<=wr_count_next.
//  - wr_count_next includes an accepted write in the same cycle. A write coinciding with
//    layer_done lands in the old write bank (the new read bank) and is counted.
//  - A read beat in the swap cycle still completes from the old read bank.
//  - A swap with wr_count=0 gives rd_len=0, so no reads occur.
//  Arithmetic:
//  - Pointers are CW bits wide, saturating at DEP as described above.
//  - No data arithmetic except the optional ReLU.
//  - overflow clears only on reset.
// CONFIGURATION
//  ACT_RELU_EN
//  - Defined: on write, data with sign bit 1 is stored as 0; non-negative data is stored unchanged.
//  - Not defined: wr_data is stored verbatim.
//  - The ext_data path is never rectified.
// TESTING
//  1. Assert rst_in for 2 cycles -> all outputs 0, bank_sel=0, rd_valid=0.
//  2. input_layer=1, ext 5,6,7 on 3 cycles -> rd_data 5,6,7 one cycle later, rd_valid=1 each cycle.
//  3. input_layer=0, write 10,20,30, then pulse layer_done -> bank_sel=1;
//     rd_data 10,20,30 on the next 3 cycles, then rd_valid=0.
//  4. During replay of 10,20,30, feed_hold=1 for 2 cycles after the first beat ->
//     rd_data holds 10, rd_valid=0; resumes with 20,30.
//  5. Write 9 values with DEP=8 -> wr_count=8, overflow=1; after the swap, exactly 8 values
//     replay and the 9th is absent.
//  6. 2 writes, then a 3rd write in the same cycle as layer_done -> rd_len=3, all 3 replay.
//  7. With ACT_RELU_EN, write -5 then 4, then swap -> replay 0, 4.
//     Without the macro -> replay -5, 4.
//  8. Assert rst_in mid-replay -> rd_valid=0 next cycle, bank_sel=0.

Source files
------------

// File: rtl/act_pingpong_buf_if.sv
// Handshake/bus bundle for the ping-pong activation buffer.
// master: the controller/PE-array side driving the buffer.
// slave : the buffer itself.
interface act_pingpong_buf_if #(
  parameter int DEP = 8,
  parameter int DW  = 16
);
  localparam int CW = $clog2(DEP + 1);

  logic          layer_done;
  logic          input_layer;
  logic          feed_hold;
  logic          ext_valid;
  logic [DW-1:0] ext_data;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] wr_count;
  logic          bank_sel;
  logic          overflow;

  modport master (
    output layer_done, input_layer, feed_hold, ext_valid, ext_data, wr_valid, wr_data,
    input  rd_valid, rd_data, wr_count, bank_sel, overflow
  );

  modport slave (
    input  layer_done, input_layer, feed_hold, ext_valid, ext_data, wr_valid, wr_data,
    output rd_valid, rd_data, wr_count, bank_sel, overflow
  );
endinterface

// File: rtl/act_pingpong_buf.sv
// Double-banked activation buffer.
// One bank captures PE results for the current layer while the other replays
// the previous layer's results; layer_done swaps the roles. In the input layer
// the read side passes the external sample stream through instead.
// Optional feature macro: ACT_RELU_EN (rectify PE results on write).
module act_pingpong_buf #(
  parameter int DEP = 8,
  parameter int DW  = 16
) (
  input  logic               clk,
  input  logic               rst_in,
  act_pingpong_buf_if.slave  bus
);
  localparam int CW = $clog2(DEP + 1);
  localparam int AW = (DEP > 1) ? $clog2(DEP) : 1;

  logic [DW-1:0] r_mem [2][DEP];

  logic          r_bank_sel;
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_rd_len;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic          r_overflow;

  logic          w_wr_acc;
  logic          w_rd_fire;
  logic [CW-1:0] w_wr_cnt_nxt;
  logic [DW-1:0] w_wr_dat;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  // A write is taken only while the write bank still has room.
  assign w_wr_acc     = bus.wr_valid && !rst_in && (r_wr_ptr < CW'(DEP));
  // Count including this cycle's write, so a write coinciding with a swap is replayed.
  assign w_wr_cnt_nxt = r_wr_ptr + CW'(w_wr_acc);
  assign w_rd_fire    = !bus.input_layer && !bus.feed_hold && (r_rd_ptr < r_rd_len);
  // Pointers only index the RAM while below DEP, so the low bits suffice.
  assign w_wr_idx     = r_wr_ptr[AW-1:0];
  assign w_rd_idx     = r_rd_ptr[AW-1:0];

`ifdef ACT_RELU_EN
  assign w_wr_dat = bus.wr_data[DW-1] ? '0 : bus.wr_data;
`else
  assign w_wr_dat = bus.wr_data;
`endif

  // Bank RAM: write side always targets the bank not being read; no reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[~r_bank_sel][w_wr_idx] <= w_wr_dat;
  end

  // Pointers, bank swap, read stream and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_bank_sel <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_len   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (bus.input_layer) begin
        r_rd_valid <= bus.ext_valid;
        r_rd_data  <= bus.ext_data;
      end else if (w_rd_fire) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= r_mem[r_bank_sel][w_rd_idx];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end

      if (bus.wr_valid && !w_wr_acc) r_overflow <= 1'b1;

      // Swap overrides the pointer updates above; the read beat already
      // sampled the old read bank this cycle.
      if (bus.layer_done) begin
        r_bank_sel <= ~r_bank_sel;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_rd_len   <= w_wr_cnt_nxt;
      end else begin
        r_wr_ptr   <= w_wr_cnt_nxt;
      end
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.wr_count = r_wr_ptr;
  assign bus.bank_sel = r_bank_sel;
  assign bus.overflow = r_overflow;
endmodule
